// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared widths and result type for the 4-bit adder and its benches
// Revision : 1.0
// ============================================================================
package adder_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 7;

    typedef logic [DATA_W-1:0] result_t;

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo
// Purpose  : Synchronous FIFO with a registered head-of-queue output register
// Revision : 1.0
// ============================================================================
module result_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = adder_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_pop   = pop_i && !w_empty;
    assign w_push  = push_i && (!w_full || w_pop);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (w_push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (w_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - CNT_W'(1);
        end
        // The head register always mirrors the entry that will sit at the head
        // after this edge; when the queue drains it keeps the last value.
        if (w_push && (w_empty || (w_pop && count_q == CNT_W'(1)))) begin
            rd_data_d = push_data_i;
        end else if (w_pop && count_q > CNT_W'(1)) begin
            rd_data_d = mem_q[head_q + PTR_W'(1)];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;
    assign full_o    = w_full;
    assign empty_o   = w_empty;

endmodule
`default_nettype wire

// File: rtl/adder_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : adder_result_collector
// Purpose  : Captures adder sums one cycle after valid, queues them, and
//            keeps a wrapping accumulation of every captured result
// Revision : 1.0
// ============================================================================
module adder_result_collector
    import adder_pkg::*;
#(
    parameter int DATA_W = adder_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [ACC_W-1:0]         acc
);

    logic             valid_d_q;
    logic             overflow_q, overflow_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             w_cap;
    logic             w_pop;
    logic             w_drop;

    // The adder registers its sum on the valid edge, so the sum is stable
    // exactly while the delayed strobe is high.
    assign w_cap  = valid_d_q;
    assign w_pop  = !empty && out_ready;
    assign w_drop = w_cap && full && !w_pop;

    always_comb begin
        overflow_d = overflow_q | w_drop;
        acc_d      = acc_q;
        if (w_cap) begin
            acc_d = acc_q + ACC_W'(c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_d_q  <= 1'b0;
            overflow_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            valid_d_q  <= valid;
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_cap),
        .push_data_i (c),
        .pop_i       (out_ready),
        .rd_data_o   (out_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign acc       = acc_q;

endmodule
`default_nettype wire
